voice_request_encoder: RTL

- Reverse direction of the music engine's 3-to-8 channel select decode: collects up to 8 per-voice request lines and encodes them into a 3-bit voice index.
- The index is presented to the downstream note sequencer over a valid/ready handshake.
- Requests are latched as sticky pending bits and arbitrated round-robin, so no voice starves.
- Also tracks coalesced (dropped) requests for debug.

---
 rtl/voice_request_encoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/voice_request_encoder.sv
// Sticky 8-voice request collector with round-robin encode to a 3-bit index over valid/ready.
// Define FIXED_PRIORITY_EN to freeze the round-robin pointer at 0 (lowest index wins).
module voice_request_encoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic [2:0]       sel,
    output logic             sel_valid,
    input  logic             sel_ready,
    output logic [7:0]       pending,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       rr_ptr, rr_nxt;
    logic [2:0]       sel_nxt;
    logic             sel_valid_nxt;
    logic [2:0]       pick;
    logic [2:0]       idx;
    logic             acc;
    logic [7:0]       am;
    logic [7:0]       avail;
    logic [7:0]       coal;
    logic [3:0]       coal_cnt;
    logic [CNT_W+3:0] drop_sum;
    logic [CNT_W-1:0] drop_nxt;

    assign acc   = sel_valid & sel_ready;
    assign am    = acc ? (8'b1 << sel) : 8'b0;
    assign avail = pending & ~am;
    assign coal  = req & avail;

    // Descending scan so the smallest offset from rr_ptr is the one that sticks.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int k = 7; k >= 0; k--) begin
            idx = rr_ptr + 3'(k);
            if (avail[idx]) pick = idx;
        end
    end

    always_comb begin
        coal_cnt = '0;
        for (int i = 0; i < 8; i++) coal_cnt = coal_cnt + {3'b0, coal[i]};
        drop_sum = {4'b0, drop_cnt} + {{CNT_W{1'b0}}, coal_cnt};
        if (drop_sum > {4'b0, {CNT_W{1'b1}}}) drop_nxt = '1;
        else                                  drop_nxt = drop_sum[CNT_W-1:0];
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        sel_valid_nxt = sel_valid;
        rr_nxt        = rr_ptr;
        case (state)
            IDLE: begin
                if (pending != 8'b0) begin
                    sel_nxt       = pick;
                    sel_valid_nxt = 1'b1;
                    state_nxt     = OFFER;
                end
            end
            OFFER: begin
                if (acc) begin
`ifndef FIXED_PRIORITY_EN
                    rr_nxt = sel + 3'd1;
`endif
                    if (avail != 8'b0) begin
                        sel_nxt = pick;
                    end else begin
                        sel_valid_nxt = 1'b0;
                        state_nxt     = IDLE;
                    end
                end
            end
            default: begin
                state_nxt     = IDLE;
                sel_valid_nxt = 1'b0;
            end
        endcase
    end

    // A new request on the bit being accepted this edge re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            sel_valid <= 1'b0;
            rr_ptr    <= '0;
            pending   <= '0;
            drop_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            sel_valid <= sel_valid_nxt;
            rr_ptr    <= rr_nxt;
            pending   <= avail | req;
            drop_cnt  <= drop_nxt;
        end
    end

endmodule
